// File: rtl/dffa_arbiter.sv
// Controller sharing one load-enabled dffa register among four requesters.
// Define DFFA_ARB_RR_EN for round-robin selection; otherwise fixed priority (req[0] highest).
`timescale 1ns/1ps

module dffa_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic               load,
  output logic [WIDTH-1:0]   da,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       win;
  logic [3:0]       win_oh;
  logic [WIDTH-1:0] win_data;

`ifdef DFFA_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  // Search upward from ptr; descending loop leaves the nearest set bit as winner.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`endif

  always_comb begin
    win_oh   = 4'b0001 << win;
    win_data = din[int'(win)*WIDTH +: WIDTH];
  end

  // Single-process FSM; strobes default low and are raised only on the grant edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      ack   <= 4'b0000;
      load  <= 1'b0;
      da    <= '0;
      busy  <= 1'b0;
`ifdef DFFA_ARB_RR_EN
      ptr   <= 2'd0;
`endif
    end else begin
      gnt  <= 4'b0000;
      ack  <= 4'b0000;
      load <= 1'b0;
      busy <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= LOAD;
            gnt   <= win_oh;
            ack   <= win_oh;
            load  <= 1'b1;
            da    <= win_data;
            busy  <= 1'b1;
`ifdef DFFA_ARB_RR_EN
            ptr   <= win + 2'd1;
`endif
          end
        end
        LOAD: begin
          state <= DONE;
          busy  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dffa_arbiter.sv
// Scoreboard bench for dffa_arbiter: a grant-level reference model predicts each
// grant, a negedge monitor checks DUT outputs and the downstream dffa contents.
`timescale 1ns/1ps

module tb_dffa_arbiter;

  localparam int unsigned WIDTH = 4;
`ifdef DFFA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               clr = 1'b1;
  logic [3:0]         req = 4'b0000;
  logic [4*WIDTH-1:0] din = '0;
  logic [3:0]         gnt;
  logic [3:0]         ack;
  logic               load;
  logic [WIDTH-1:0]   da;
  logic               busy;
  logic [WIDTH-1:0]   qa;

  always #5 clk = ~clk;

  dffa_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .req (req),
    .din (din),
    .gnt (gnt),
    .ack (ack),
    .load(load),
    .da  (da),
    .busy(busy)
  );

  // Downstream dffa register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) qa <= '0;
    else if (load) qa <= da;
  end

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
  } exp_t;

  typedef struct {
    int idx;
    int cyc;
  } glog_t;

  exp_t  sb[$];
  glog_t gnt_log[$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  int   cool     = 0;
  int   m_ptr    = 0;
  logic exp_load = 1'b0;
  logic exp_busy = 1'b0;

  logic [3:0]       drop_mask = 4'b0000;
  bit               auto_drop = 1'b1;
  logic [WIDTH-1:0] qa_exp    = '0;
  bit               pending_qa = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: one grant per three edges, winner by pointer search.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      cool     = 0;
      m_ptr    = 0;
      exp_load = 1'b0;
      exp_busy = 1'b0;
      sb.delete();
    end else begin
      exp_load = 1'b0;
      if (cool > 0) begin
        cool--;
      end else if (req != 4'b0000) begin
        exp_t e;
        e.idx  = pick(req, m_ptr);
        e.data = din[e.idx*WIDTH +: WIDTH];
        sb.push_back(e);
        m_ptr    = RR ? (e.idx + 1) % 4 : 0;
        cool     = 2;
        exp_load = 1'b1;
      end
      exp_busy = (cool > 0);
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    glog_t g;
    if (clr) begin
      pending_qa = 1'b0;
    end else begin
      if (pending_qa) begin
        chk("qa", 32'(qa), 32'(qa_exp));
        pending_qa = 1'b0;
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("load", 32'(load), 32'(exp_load));
      if (load) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("gnt", 32'(gnt), 32'(4'b0001 << e.idx));
          chk("ack", 32'(ack), 32'(4'b0001 << e.idx));
          chk("da", 32'(da), 32'(e.data));
          qa_exp     = e.data;
          pending_qa = 1'b1;
        end
        g.idx = onehot_idx(gnt);
        g.cyc = cyc;
        gnt_log.push_back(g);
      end else begin
        chk("gnt_idle", 32'(gnt), 32'd0);
        chk("ack_idle", 32'(ack), 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    req       = req & ~drop_mask;
    drop_mask = auto_drop ? (ack & req) : 4'b0000;
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!load && n < 20);
    if (!load) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_grants(input int cnt, input string name);
    int n;
    n = 0;
    while (gnt_log.size() < cnt && n < 100) begin
      step();
      n++;
    end
    if (gnt_log.size() < cnt) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic settle();
    int n;
    n = 0;
    auto_drop = 1'b1;
    do begin
      step();
      n++;
    end while ((req != 4'b0000 || busy || load) && n < 80);
    if (req != 4'b0000 || busy || load) chk("settle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_da", 32'(da), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 clr = 1'b0;

    // Single requester
    din[8 +: 4] = 4'hA;
    req = 4'b0100;
    wait_load("single");
    chk("single_gnt", 32'(gnt), 32'(4'b0100));
    chk("single_da", 32'(da), 32'hA);
    step();
    chk("single_ack_fall", 32'(ack), 32'd0);
    chk("single_qa", 32'(qa), 32'hA);
    step();
    chk("single_busy", 32'(busy), 32'd0);
    settle();

    // All requesters held, each dropping after its ack
    gnt_log.delete();
    req = 4'b1111;
    wait_grants(4, "all");
    for (int j = 0; j < 4 && j < gnt_log.size(); j++) chk("all_order", 32'(gnt_log[j].idx), 32'(j));
    for (int j = 1; j < 4 && j < gnt_log.size(); j++)
      chk("all_spacing", 32'(gnt_log[j].cyc - gnt_log[j-1].cyc), 32'd3);
    settle();
    gnt_log.delete();
    req = 4'b1001;
    wait_grants(1, "wrap");
    if (gnt_log.size() > 0) chk("wrap_first", 32'(gnt_log[0].idx), 32'd0);
    settle();

    // Continuous hog
    auto_drop = 1'b0;
    gnt_log.delete();
    req = 4'b0011;
    wait_grants(4, "hog");
    for (int j = 0; j < 4 && j < gnt_log.size(); j++)
      chk("hog_order", 32'(gnt_log[j].idx), RR ? 32'(j % 2) : 32'd0);
    req = 4'b0000;
    settle();

    // Reset mid-LOAD
    din = 16'hFEDC;
    req = 4'b0111;
    wait_load("rst_mid");
    #2 clr = 1'b1;
    #1;
    chk("rstmid_load", 32'(load), 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_da", 32'(da), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    drop_mask = 4'b0000;
    step();
    step();
    req = 4'b1000;
    clr = 1'b0;
    wait_load("rst_rel");
    chk("rstrel_gnt", 32'(gnt), 32'(4'b1000));
    settle();

    // Request raised during DONE
    din[0 +: 4] = 4'h6;
    req = 4'b0001;
    wait_load("done");
    step();
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_load", 32'(load), 32'd0);
    req = req | 4'b0010;
    din[4 +: 4] = 4'h3;
    step();
    chk("done_no_grant", 32'(load), 32'd0);
    din[4 +: 4] = 4'h9;
    step();
    chk("done_gnt", 32'(gnt), 32'(4'b0010));
    chk("done_da", 32'(da), 32'h9);
    settle();

    // Data change after grant
    din[8 +: 4] = 4'h5;
    req = 4'b0100;
    wait_load("chg");
    din[8 +: 4] = 4'hC;
    step();
    chk("chg_qa", 32'(qa), 32'h5);
    settle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step();
      r   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req = req | r;
      din = 16'($urandom);
    end
    settle();
    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
